// File: rtl/rv32_encoder_if.sv
// ---------------------------------------------------------------------------
// rv32_encoder_if
//   Handshake bundle between a field producer, the rv32_encoder and the
//   consumer of the encoded words.
//
//   Input side  : in_valid / in_ready, plus the decoded fields
//                 in_op, in_rd, in_rs1, in_rs2, in_imm
//   Output side : out_valid / out_ready, plus out_inst and out_err
//
//   master : the environment. It drives the fields and out_ready.
//   slave  : the encoder. It drives in_ready and the output word.
// ---------------------------------------------------------------------------
interface rv32_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_op;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_err;

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        input  in_ready, out_valid, out_inst, out_err
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        output in_ready, out_valid, out_inst, out_err
    );
endinterface

// File: rtl/rv32_encoder.sv
// ---------------------------------------------------------------------------
// rv32_encoder
//   Pipelined RV32I instruction encoder. This block is the inverse of the core's
//   instruction decoder. It takes decoded fields (opcode enum, register
//   indices, immediate) and produces 32-bit instruction words. The words
//   pass through an output FIFO that absorbs consumer backpressure.
//   Fields that cannot be encoded produce an error entry. An error entry
//   has out_err=1 and out_inst=0.
//
//   Ports
//     clk       : rising-edge clock
//     rst_n     : asynchronous active-low reset
//     bus       : rv32_encoder_if.slave (input fields plus output word handshakes)
//     enc_count : number of words pushed into the FIFO, modulo 2^16
//
//   Pipeline
//     S1   : one register holding the accepted fields.
//     push : S1 is encoded combinationally and written into the FIFO
//            when S1 is valid and the FIFO is not full.
// ---------------------------------------------------------------------------
module rv32_encoder #(
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    rv32_encoder_if.slave  bus,
    output logic [15:0]    enc_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE  = (AW + 1)'(1);
    localparam logic [AW:0] PTR_WRAP = {1'b1, {AW{1'b0}}};

    // Opcode enum values, in the decoder's enumeration order. Value 31 is illegal.
    localparam logic [4:0] OP_LUI   = 5'd0;
    localparam logic [4:0] OP_AUIPC = 5'd1;
    localparam logic [4:0] OP_JAL   = 5'd2;
    localparam logic [4:0] OP_JALR  = 5'd3;
    localparam logic [4:0] OP_BEQ   = 5'd4;
    localparam logic [4:0] OP_BNE   = 5'd5;
    localparam logic [4:0] OP_BLT   = 5'd6;
    localparam logic [4:0] OP_BGE   = 5'd7;
    localparam logic [4:0] OP_BLTU  = 5'd8;
    localparam logic [4:0] OP_BGEU  = 5'd9;
    localparam logic [4:0] OP_LW    = 5'd10;
    localparam logic [4:0] OP_SW    = 5'd11;
    localparam logic [4:0] OP_ADDI  = 5'd12;
    localparam logic [4:0] OP_SLTI  = 5'd13;
    localparam logic [4:0] OP_SLTIU = 5'd14;
    localparam logic [4:0] OP_XORI  = 5'd15;
    localparam logic [4:0] OP_ORI   = 5'd16;
    localparam logic [4:0] OP_ANDI  = 5'd17;
    localparam logic [4:0] OP_SLLI  = 5'd18;
    localparam logic [4:0] OP_SRLI  = 5'd19;
    localparam logic [4:0] OP_SRAI  = 5'd20;
    localparam logic [4:0] OP_ADD   = 5'd21;
    localparam logic [4:0] OP_SUB   = 5'd22;
    localparam logic [4:0] OP_SLL   = 5'd23;
    localparam logic [4:0] OP_SLT   = 5'd24;
    localparam logic [4:0] OP_SLTU  = 5'd25;
    localparam logic [4:0] OP_XOR   = 5'd26;
    localparam logic [4:0] OP_SRL   = 5'd27;
    localparam logic [4:0] OP_SRA   = 5'd28;
    localparam logic [4:0] OP_OR    = 5'd29;
    localparam logic [4:0] OP_AND   = 5'd30;

    localparam logic [6:0] MAJ_LUI    = 7'b0110111;
    localparam logic [6:0] MAJ_AUIPC  = 7'b0010111;
    localparam logic [6:0] MAJ_JAL    = 7'b1101111;
    localparam logic [6:0] MAJ_JALR   = 7'b1100111;
    localparam logic [6:0] MAJ_BRANCH = 7'b1100011;
    localparam logic [6:0] MAJ_LOAD   = 7'b0000011;
    localparam logic [6:0] MAJ_STORE  = 7'b0100011;
    localparam logic [6:0] MAJ_OPIMM  = 7'b0010011;
    localparam logic [6:0] MAJ_OP     = 7'b0110011;

    localparam logic [6:0] F7_ALT = 7'b0100000;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_SH, FMT_BAD
    } fmt_e;

    // ---------------- Stage 1 ----------------
    logic        s1_valid_reg;
    logic [4:0]  s1_op_reg;
    logic [4:0]  s1_rd_reg;
    logic [4:0]  s1_rs1_reg;
    logic [4:0]  s1_rs2_reg;
    logic [31:0] s1_imm_reg;

    // ---------------- FIFO state ----------------
    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;
    logic [31:0] fifo_inst_mem [DEPTH];
    logic        fifo_err_mem  [DEPTH];
    logic [15:0] enc_count_reg;

    logic fifo_full;
    logic fifo_empty;
    logic accept;
    logic push;
    logic pop;

    // The FIFO is full when the pointers have the same index and differ only
    // in the wrap bit.
    assign fifo_full  = ((wr_ptr_reg ^ rd_ptr_reg) == PTR_WRAP);
    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);

    // in_ready depends only on state. It does not depend on out_ready, so
    // there is no combinational path from the consumer to the producer.
    assign bus.in_ready = !s1_valid_reg || !fifo_full;
    assign accept       = bus.in_valid && bus.in_ready;
    assign push         = s1_valid_reg && !fifo_full;
    assign pop          = !fifo_empty && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_op_reg    <= '0;
            s1_rd_reg    <= '0;
            s1_rs1_reg   <= '0;
            s1_rs2_reg   <= '0;
            s1_imm_reg   <= '0;
        end else if (accept) begin
            s1_valid_reg <= 1'b1;
            s1_op_reg    <= bus.in_op;
            s1_rd_reg    <= bus.in_rd;
            s1_rs1_reg   <= bus.in_rs1;
            s1_rs2_reg   <= bus.in_rs2;
            s1_imm_reg   <= bus.in_imm;
        end else if (push) begin
            s1_valid_reg <= 1'b0;
        end
    end

    // ---------------- Stage 2: opcode decode ----------------
    fmt_e       fmt;
    logic [6:0] maj;
    logic [2:0] f3;
    logic [6:0] f7;

    always_comb begin
        fmt = FMT_BAD;
        maj = 7'b0;
        f3  = 3'b000;
        f7  = 7'b0;
        case (s1_op_reg)
            OP_LUI:   begin fmt = FMT_U;  maj = MAJ_LUI;   end
            OP_AUIPC: begin fmt = FMT_U;  maj = MAJ_AUIPC; end
            OP_JAL:   begin fmt = FMT_J;  maj = MAJ_JAL;   end
            OP_JALR:  begin fmt = FMT_I;  maj = MAJ_JALR;   f3 = 3'b000; end
            OP_BEQ:   begin fmt = FMT_B;  maj = MAJ_BRANCH; f3 = 3'b000; end
            OP_BNE:   begin fmt = FMT_B;  maj = MAJ_BRANCH; f3 = 3'b001; end
            OP_BLT:   begin fmt = FMT_B;  maj = MAJ_BRANCH; f3 = 3'b100; end
            OP_BGE:   begin fmt = FMT_B;  maj = MAJ_BRANCH; f3 = 3'b101; end
            OP_BLTU:  begin fmt = FMT_B;  maj = MAJ_BRANCH; f3 = 3'b110; end
            OP_BGEU:  begin fmt = FMT_B;  maj = MAJ_BRANCH; f3 = 3'b111; end
            OP_LW:    begin fmt = FMT_I;  maj = MAJ_LOAD;   f3 = 3'b010; end
            OP_SW:    begin fmt = FMT_S;  maj = MAJ_STORE;  f3 = 3'b010; end
            OP_ADDI:  begin fmt = FMT_I;  maj = MAJ_OPIMM;  f3 = 3'b000; end
            OP_SLTI:  begin fmt = FMT_I;  maj = MAJ_OPIMM;  f3 = 3'b010; end
            OP_SLTIU: begin fmt = FMT_I;  maj = MAJ_OPIMM;  f3 = 3'b011; end
            OP_XORI:  begin fmt = FMT_I;  maj = MAJ_OPIMM;  f3 = 3'b100; end
            OP_ORI:   begin fmt = FMT_I;  maj = MAJ_OPIMM;  f3 = 3'b110; end
            OP_ANDI:  begin fmt = FMT_I;  maj = MAJ_OPIMM;  f3 = 3'b111; end
            OP_SLLI:  begin fmt = FMT_SH; maj = MAJ_OPIMM;  f3 = 3'b001; end
            OP_SRLI:  begin fmt = FMT_SH; maj = MAJ_OPIMM;  f3 = 3'b101; end
            OP_SRAI:  begin fmt = FMT_SH; maj = MAJ_OPIMM;  f3 = 3'b101; f7 = F7_ALT; end
            OP_ADD:   begin fmt = FMT_R;  maj = MAJ_OP;     f3 = 3'b000; end
            OP_SUB:   begin fmt = FMT_R;  maj = MAJ_OP;     f3 = 3'b000; f7 = F7_ALT; end
            OP_SLL:   begin fmt = FMT_R;  maj = MAJ_OP;     f3 = 3'b001; end
            OP_SLT:   begin fmt = FMT_R;  maj = MAJ_OP;     f3 = 3'b010; end
            OP_SLTU:  begin fmt = FMT_R;  maj = MAJ_OP;     f3 = 3'b011; end
            OP_XOR:   begin fmt = FMT_R;  maj = MAJ_OP;     f3 = 3'b100; end
            OP_SRL:   begin fmt = FMT_R;  maj = MAJ_OP;     f3 = 3'b101; end
            OP_SRA:   begin fmt = FMT_R;  maj = MAJ_OP;     f3 = 3'b101; f7 = F7_ALT; end
            OP_OR:    begin fmt = FMT_R;  maj = MAJ_OP;     f3 = 3'b110; end
            OP_AND:   begin fmt = FMT_R;  maj = MAJ_OP;     f3 = 3'b111; end
            default:  begin fmt = FMT_BAD; end
        endcase
    end

    // ---------------- Stage 2: field packing and range checks ----------------
    logic [31:0] imm;
    logic [31:0] enc_word;
    logic        enc_bad;
    logic [31:0] enc_inst;
    logic        enc_err;

    assign imm = s1_imm_reg;

    // Signed N-bit range check: every bit from N-1 up to 31 must equal the sign bit.
    // A format that does not use rs1, rs2 or rd encodes that field as zero,
    // whatever the input value.
    always_comb begin
        enc_word = 32'b0;
        enc_bad  = 1'b0;
        case (fmt)
            FMT_R: begin
                enc_word = {f7, s1_rs2_reg, s1_rs1_reg, f3, s1_rd_reg, maj};
            end
            FMT_I: begin
                enc_bad  = !((&imm[31:11]) || !(|imm[31:11]));
                enc_word = {imm[11:0], s1_rs1_reg, f3, s1_rd_reg, maj};
            end
            FMT_S: begin
                enc_bad  = !((&imm[31:11]) || !(|imm[31:11]));
                enc_word = {imm[11:5], s1_rs2_reg, s1_rs1_reg, f3, imm[4:0], maj};
            end
            FMT_B: begin
                enc_bad  = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
                enc_word = {imm[12], imm[10:5], s1_rs2_reg, s1_rs1_reg, f3,
                            imm[4:1], imm[11], maj};
            end
            FMT_U: begin
                enc_bad  = |imm[11:0];
                enc_word = {imm[31:12], s1_rd_reg, maj};
            end
            FMT_J: begin
                enc_bad  = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
                enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], s1_rd_reg, maj};
            end
            FMT_SH: begin
                enc_bad  = |imm[31:5];
                enc_word = {f7, imm[4:0], s1_rs1_reg, f3, s1_rd_reg, maj};
            end
            default: begin
                enc_bad  = 1'b1;
            end
        endcase
    end

    // An error entry carries an all-zero instruction word.
    assign enc_err  = enc_bad;
    assign enc_inst = enc_bad ? 32'b0 : enc_word;

    // ---------------- Output FIFO ----------------
    // The storage has no reset. Its contents matter only between the pointers,
    // and reset makes both pointers equal.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_inst_mem[wr_ptr_reg[AW-1:0]] <= enc_inst;
            fifo_err_mem[wr_ptr_reg[AW-1:0]]  <= enc_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            enc_count_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg    <= wr_ptr_reg + PTR_ONE;
                enc_count_reg <= enc_count_reg + 16'd1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
        end
    end

    // The head of the FIFO is shown directly, with no bypass.
    // A word pushed into an empty FIFO appears one cycle after the push.
    assign bus.out_valid = !fifo_empty;
    assign bus.out_inst  = fifo_empty ? 32'b0 : fifo_inst_mem[rd_ptr_reg[AW-1:0]];
    assign bus.out_err   = fifo_empty ? 1'b0  : fifo_err_mem[rd_ptr_reg[AW-1:0]];
    assign enc_count     = enc_count_reg;

endmodule

// File: tb/tb_rv32_encoder.sv
// ---------------------------------------------------------------------------
// tb_rv32_encoder
//   Directed testbench for rv32_encoder with DEPTH=4. The expected
//   instruction words were worked out by hand from the RV32I field layout.
// ---------------------------------------------------------------------------
module tb_rv32_encoder;

    localparam logic [4:0] OP_LUI  = 5'd0;
    localparam logic [4:0] OP_JAL  = 5'd2;
    localparam logic [4:0] OP_BEQ  = 5'd4;
    localparam logic [4:0] OP_SW   = 5'd11;
    localparam logic [4:0] OP_ADDI = 5'd12;
    localparam logic [4:0] OP_SLLI = 5'd18;
    localparam logic [4:0] OP_SRAI = 5'd20;
    localparam logic [4:0] OP_ADD  = 5'd21;
    localparam logic [4:0] OP_SUB  = 5'd22;
    localparam logic [4:0] OP_BAD  = 5'd31;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] enc_count;
    int          n_cmp = 0;
    int          n_bad = 0;

    rv32_encoder_if bus ();

    rv32_encoder #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .enc_count (enc_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] exp_inst;
        logic        exp_err;
    } vec_t;

    // Presents the fields and waits up to max_wait cycles for them to be accepted.
    // Call it just after a falling edge. It returns just after the falling edge
    // that follows the accepting rising edge.
    task automatic send(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm,
                        input int max_wait, output bit acc);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_rd    = rd;
        bus.in_rs1   = rs1;
        bus.in_rs2   = rs2;
        bus.in_imm   = imm;
        acc = 1'b0;
        for (int c = 0; c < max_wait; c++) begin
            if (bus.in_ready) begin
                @(posedge clk);
                acc = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
    endtask

    // Sends one word and records out_valid one edge and two edges after acceptance,
    // along with the head word. It then pops that word.
    task automatic run_one(input vec_t v, output bit acc, output logic v_early,
                           output logic v_late, output logic [31:0] inst, output logic err);
        send(v.op, v.rd, v.rs1, v.rs2, v.imm, 10, acc);
        v_early = bus.out_valid;
        @(negedge clk);
        v_late = bus.out_valid;
        inst   = bus.out_inst;
        err    = bus.out_err;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        n_cmp++; if (bus.out_inst !== 32'h0) begin n_bad++; $display("FAIL reset_out_inst: got %h expected 00000000", bus.out_inst); end
        n_cmp++; if (bus.out_err !== 1'b0) begin n_bad++; $display("FAIL reset_out_err: got %b expected 0", bus.out_err); end
        n_cmp++; if (enc_count !== 16'h0) begin n_bad++; $display("FAIL reset_enc_count: got %h expected 0000", enc_count); end
        $display("test_reset: done");
    endtask

    task automatic run_table(input string tag, input vec_t tbl[]);
        bit acc;
        logic ve, vl, err;
        logic [31:0] inst;
        foreach (tbl[i]) begin
            run_one(tbl[i], acc, ve, vl, inst, err);
            n_cmp++; if (acc !== 1'b1) begin n_bad++; $display("FAIL %s_accept[%0d]: got %b expected 1", tag, i, acc); end
            n_cmp++; if (ve !== 1'b0) begin n_bad++; $display("FAIL %s_early_valid[%0d]: got %b expected 0", tag, i, ve); end
            n_cmp++; if (vl !== 1'b1) begin n_bad++; $display("FAIL %s_valid[%0d]: got %b expected 1", tag, i, vl); end
            n_cmp++; if (inst !== tbl[i].exp_inst) begin n_bad++; $display("FAIL %s_inst[%0d]: got %h expected %h", tag, i, inst, tbl[i].exp_inst); end
            n_cmp++; if (err !== tbl[i].exp_err) begin n_bad++; $display("FAIL %s_err[%0d]: got %b expected %b", tag, i, err, tbl[i].exp_err); end
            $display("%s[%0d]: op=%0d imm=%h inst=%h err=%b", tag, i, tbl[i].op, tbl[i].imm, inst, err);
        end
    endtask

    task automatic test_basic();
        vec_t tbl[];
        tbl = '{
            '{OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5,        32'h00500093, 1'b0},
            '{OP_ADD,  5'd3, 5'd1, 5'd2, 32'd0,        32'h002081B3, 1'b0},
            '{OP_SUB,  5'd3, 5'd1, 5'd2, 32'd0,        32'h402081B3, 1'b0},
            '{OP_ADDI, 5'd1, 5'd0, 5'd0, 32'hFFFFF800, 32'h80000093, 1'b0},
            '{OP_SW,   5'd9, 5'd2, 5'd3, 32'hFFFFFFFC, 32'hFE312E23, 1'b0},
            '{OP_SRAI, 5'd1, 5'd1, 5'd0, 32'd3,        32'h4030D093, 1'b0},
            '{OP_JAL,  5'd1, 5'd4, 5'd5, 32'd2048,     32'h001000EF, 1'b0}
        };
        run_table("basic", tbl);
    endtask

    task automatic test_utype_branch();
        vec_t tbl[];
        tbl = '{
            '{OP_LUI, 5'd5, 5'd3, 5'd4, 32'h12345000, 32'h123452B7, 1'b0},
            '{OP_BEQ, 5'd0, 5'd1, 5'd2, 32'd8,        32'h00208463, 1'b0},
            '{OP_BEQ, 5'd7, 5'd1, 5'd2, 32'd8,        32'h00208463, 1'b0}
        };
        run_table("ub", tbl);
    endtask

    task automatic test_errors();
        vec_t tbl[];
        logic [15:0] cnt0;
        cnt0 = enc_count;
        tbl = '{
            '{OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h0, 1'b1},
            '{OP_BEQ,  5'd0, 5'd1, 5'd2, 32'd3,    32'h0, 1'b1},
            '{OP_BAD,  5'd1, 5'd1, 5'd1, 32'd0,    32'h0, 1'b1},
            '{OP_SLLI, 5'd1, 5'd1, 5'd0, 32'd32,   32'h0, 1'b1}
        };
        run_table("err", tbl);
        n_cmp++; if (enc_count !== cnt0 + 16'd4) begin n_bad++; $display("FAIL err_enc_count: got %h expected %h", enc_count, cnt0 + 16'd4); end
    endtask

    task automatic test_backpressure();
        bit acc;
        int accepted;
        int got;
        logic [15:0] cnt0;
        cnt0 = enc_count;
        accepted = 0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!bus.in_ready) break;
            send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'(i), 1, acc);
            if (acc) accepted++;
        end
        n_cmp++; if (accepted !== 5) begin n_bad++; $display("FAIL bp_accepted: got %0d expected 5", accepted); end
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready_low: got %b expected 0", bus.in_ready); end
        $display("bp: accepted %0d before stall, in_ready=%b", accepted, bus.in_ready);
        bus.out_ready = 1'b1;
        got = 0;
        fork
            begin
                bit acc2;
                for (int i = accepted; i < 8; i++) begin
                    send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'(i), 40, acc2);
                    n_cmp++; if (acc2 !== 1'b1) begin n_bad++; $display("FAIL bp_send[%0d]: got %b expected 1", i, acc2); end
                end
            end
            begin
                logic [31:0] exp;
                for (int c = 0; c < 200 && got < 8; c++) begin
                    if (bus.out_valid && bus.out_ready) begin
                        exp = 32'h00000093 | (32'(got) << 20);
                        n_cmp++; if (bus.out_inst !== exp) begin n_bad++; $display("FAIL bp_word[%0d]: got %h expected %h", got, bus.out_inst, exp); end
                        $display("bp word[%0d]: inst=%h", got, bus.out_inst);
                        got++;
                    end
                    @(negedge clk);
                end
            end
        join
        repeat (3) @(negedge clk);
        n_cmp++; if (got !== 8) begin n_bad++; $display("FAIL bp_word_count: got %0d expected 8", got); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drained: got out_valid %b expected 0", bus.out_valid); end
        n_cmp++; if (enc_count !== cnt0 + 16'd8) begin n_bad++; $display("FAIL bp_enc_count: got %h expected %h", enc_count, cnt0 + 16'd8); end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_midstream();
        bit acc;
        logic ve, vl, err;
        logic [31:0] inst;
        logic [15:0] cnt0;
        vec_t v;
        cnt0 = enc_count;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'(i), 10, acc);
        @(negedge clk);
        n_cmp++; if (enc_count !== cnt0 + 16'd3) begin n_bad++; $display("FAIL rst_pre_count: got %h expected %h", enc_count, cnt0 + 16'd3); end
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL rst_pre_valid: got %b expected 1", bus.out_valid); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_async_valid: got %b expected 0", bus.out_valid); end
        n_cmp++; if (enc_count !== 16'h0) begin n_bad++; $display("FAIL rst_async_count: got %h expected 0000", enc_count); end
        n_cmp++; if (bus.out_inst !== 32'h0) begin n_bad++; $display("FAIL rst_async_inst: got %h expected 00000000", bus.out_inst); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_after_valid: got %b expected 0", bus.out_valid); end
        v = '{OP_ADDI, 5'd2, 5'd3, 5'd0, 32'hFFFFFFFF, 32'hFFF18113, 1'b0};
        run_one(v, acc, ve, vl, inst, err);
        n_cmp++; if (vl !== 1'b1) begin n_bad++; $display("FAIL rst_new_valid: got %b expected 1", vl); end
        n_cmp++; if (inst !== v.exp_inst) begin n_bad++; $display("FAIL rst_new_inst: got %h expected %h", inst, v.exp_inst); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_new_err: got %b expected 0", err); end
        n_cmp++; if (enc_count !== 16'h1) begin n_bad++; $display("FAIL rst_new_count: got %h expected 0001", enc_count); end
        $display("reset midstream: new inst=%h count=%h", inst, enc_count);
    endtask

    task automatic test_counter_wrap();
        bit found;
        found = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_op     = OP_ADDI;
        bus.in_rd     = 5'd1;
        bus.in_rs1    = 5'd0;
        bus.in_rs2    = 5'd0;
        bus.in_imm    = 32'd1;
        for (int c = 0; c < 70000; c++) begin
            @(negedge clk);
            if (enc_count == 16'hFFFF) begin
                found = 1'b1;
                break;
            end
        end
        n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL wrap_reach_ffff: got %h expected ffff", enc_count); end
        @(negedge clk);
        n_cmp++; if (enc_count !== 16'h0000) begin n_bad++; $display("FAIL wrap_to_zero: got %h expected 0000", enc_count); end
        $display("counter wrap: count after wrap=%h", enc_count);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL wrap_drained: got %b expected 0", bus.out_valid); end
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_rd     = '0;
        bus.in_rs1    = '0;
        bus.in_rs2    = '0;
        bus.in_imm    = '0;
        bus.out_ready = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        test_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_basic();
        test_utype_branch();
        test_errors();
        test_backpressure();
        test_reset_midstream();
        test_counter_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
